// File: rtl/xc_integration_ctrl.sv
// rtl/xc_integration_ctrl.sv - integration frame scheduler for the cross-correlator array
module xc_integration_ctrl #(
    parameter int TICK_WIDTH   = 32,
    parameter int CLEAR_CYCLES = 4,
    parameter int FRAME_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [TICK_WIDTH-1:0]  integration_ticks,
    input  logic                   tick,
    input  logic                   sat,
    input  logic                   tx_ready,
    output logic                   corr_enable,
    output logic                   corr_reset,
    output logic                   snapshot,
    output logic                   tx_valid,
    output logic                   frame_ovf,
    output logic [FRAME_WIDTH-1:0] frame_count,
    output logic                   busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_INTEGRATE = 3'd2;
    localparam logic [2:0] S_SNAP      = 3'd3;
    localparam logic [2:0] S_WAIT_TX   = 3'd4;

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CLR_W-1:0]      clr_cnt;
    logic [TICK_WIDTH-1:0] tick_cnt;
    logic [TICK_WIDTH-1:0] len_q;
    logic                  ovf_q;
    logic                  stop_pend;
    logic                  enter_clear;
    logic                  last_tick;

    assign last_tick   = tick && (tick_cnt == len_q - TICK_WIDTH'(1));
    assign enter_clear = (state_nxt == S_CLEAR) && (state != S_CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !stop) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (stop)                     state_nxt = S_IDLE;
                else if (clr_cnt == CLR_LAST) state_nxt = S_INTEGRATE;
            end
            S_INTEGRATE: begin
                if (stop)                  state_nxt = S_IDLE;
                else if (sat || last_tick) state_nxt = S_SNAP;
            end
            S_SNAP: begin
                state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // a stop arriving on the accepting cycle still ends framing
                if (tx_ready) state_nxt = (stop_pend || stop) ? S_IDLE : S_CLEAR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            tick_cnt  <= '0;
            len_q     <= TICK_WIDTH'(1);
            ovf_q     <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == S_CLEAR) ? clr_cnt + CLR_W'(1) : '0;

            if (enter_clear) begin
                tick_cnt <= '0;
                len_q    <= (integration_ticks == '0) ? TICK_WIDTH'(1) : integration_ticks;
                ovf_q    <= 1'b0;
            end else if (state == S_INTEGRATE) begin
                if (tick) tick_cnt <= tick_cnt + TICK_WIDTH'(1);
                if (sat)  ovf_q    <= 1'b1;
            end

            if (state_nxt == S_IDLE)
                stop_pend <= 1'b0;
            else if (stop && (state == S_SNAP || state == S_WAIT_TX))
                stop_pend <= 1'b1;
        end
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_enable <= 1'b0;
            corr_reset  <= 1'b0;
            snapshot    <= 1'b0;
            tx_valid    <= 1'b0;
            frame_ovf   <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            corr_reset  <= (state_nxt == S_CLEAR);
            corr_enable <= (state_nxt == S_INTEGRATE);
            snapshot    <= (state_nxt == S_SNAP);
            tx_valid    <= (state_nxt == S_WAIT_TX);
            busy        <= (state_nxt != S_IDLE);

            if (state_nxt == S_IDLE)
                frame_ovf <= 1'b0;
            else if (state == S_INTEGRATE && state_nxt == S_SNAP)
                frame_ovf <= ovf_q || sat;

            if (state == S_IDLE && state_nxt == S_CLEAR)
                frame_count <= '0;
            else if (state == S_WAIT_TX && tx_ready)
                frame_count <= frame_count + FRAME_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_xc_integration_ctrl.sv
// tb/tb_xc_integration_ctrl.sv - directed scoreboard bench for xc_integration_ctrl
module tb_xc_integration_ctrl;

    localparam int CLR = 4;
    localparam int FW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [31:0]   integration_ticks;
    logic          tick;
    logic          sat;
    logic          tx_ready;
    logic          corr_enable;
    logic          corr_reset;
    logic          snapshot;
    logic          tx_valid;
    logic          frame_ovf;
    logic [FW-1:0] frame_count;
    logic          busy;

    typedef struct {
        int   ticks;
        logic ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors       = 0;
    int   miscompares   = 0;
    int   cyc           = 0;
    int   ticks_seen    = 0;
    int   last_tick_cyc = -10;
    int   tick_period   = 0;
    int   sat_tick      = 0;
    int   model_fc      = 0;
    bit   exp_txv       = 1'b0;

    xc_integration_ctrl #(
        .TICK_WIDTH   (32),
        .CLEAR_CYCLES (CLR),
        .FRAME_WIDTH  (FW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .integration_ticks (integration_ticks),
        .tick              (tick),
        .sat               (sat),
        .tx_ready          (tx_ready),
        .corr_enable       (corr_enable),
        .corr_reset        (corr_reset),
        .snapshot          (snapshot),
        .tx_valid          (tx_valid),
        .frame_ovf         (frame_ovf),
        .frame_count       (frame_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for what the next edge will sample, then observe at the falling edge.
    task automatic step();
        exp_t e;
        if (corr_enable && tick) begin
            if (sat_tick != 0 && ticks_seen == sat_tick - 1) sat = 1'b1;
            ticks_seen++;
            last_tick_cyc = cyc;
        end
        if (tx_valid && tx_ready) model_fc++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        sat  = 1'b0;
        tick = (tick_period != 0) && (cyc % tick_period == 0);
        if (exp_txv) begin
            chk("tx_valid_after_snap", tx_valid, 1);
            chk("snap_one_cycle", snapshot, 0);
            exp_txv = 1'b0;
        end
        if (snapshot) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_snapshot", snapshot, 0);
            end else begin
                e = exp_q.pop_front();
                chk("snap_ticks", ticks_seen, e.ticks);
                chk("snap_frame_ovf", frame_ovf, e.ovf);
                chk("snap_after_last_tick", cyc, last_tick_cyc + 1);
                chk("snap_enable_low", corr_enable, 0);
                chk("snap_frame_count", frame_count, model_fc % 256);
            end
            ticks_seen = 0;
            exp_txv    = 1'b1;
        end
    endtask

    task automatic start_frame();
        start      = 1'b1;
        model_fc   = 0;
        ticks_seen = 0;
        step();
        start      = 1'b0;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return snapshot;
            1:       return corr_enable;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (sel(which) !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk(tag, sel(which), 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; sat = 1'b0;
        tx_ready = 1'b0; integration_ticks = 32'd5;
        step();
        step();
        chk("reset_outputs", {corr_enable, corr_reset, snapshot, tx_valid, frame_ovf, busy}, 0);
        chk("reset_frame_count", frame_count, 0);
        reset = 1'b1;
        step();
        chk("idle_after_release", busy, 0);

        // basic frame
        tick_period = 3;
        tx_ready    = 1'b1;
        exp_q.push_back('{5, 1'b0});
        start_frame();
        for (int i = 0; i < CLR; i++) begin
            chk("clear_reset_high", corr_reset, 1);
            chk("clear_enable_low", corr_enable, 0);
            step();
        end
        chk("enable_rise", corr_enable, 1);
        chk("reset_fall", corr_reset, 0);
        wait_for(0, "basic_snap");
        step();
        step();
        chk("basic_frame_count", frame_count, 1);
        chk("basic_reclear", corr_reset, 1);

        // backpressure on frame 2; frame 3 will saturate
        exp_q.push_back('{5, 1'b0});
        wait_for(0, "bp_snap");
        tx_ready          = 1'b0;
        integration_ticks = 32'd100;
        sat_tick          = 7;
        exp_q.push_back('{7, 1'b1});
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_tx_valid_held", tx_valid, 1);
            chk("bp_enable_low", corr_enable, 0);
            chk("bp_count_hold", frame_count, 1);
        end
        tx_ready = 1'b1;
        step();
        chk("bp_count_inc", frame_count, 2);
        chk("bp_tx_valid_drop", tx_valid, 0);
        chk("bp_reclear", corr_reset, 1);

        // saturation frame, then a clean 100-tick frame
        wait_for(0, "sat_snap");
        chk("sat_frame_ovf", frame_ovf, 1);
        sat_tick = 0;
        exp_q.push_back('{100, 1'b0});
        wait_for(1, "nosat_enable");
        integration_ticks = 32'd5;
        wait_for(0, "nosat_snap");
        chk("nosat_frame_ovf", frame_ovf, 0);

        // stop at tick 3 of 5
        wait_for(1, "abort_enable");
        begin
            int n = 0;
            while (ticks_seen < 3 && n < 100) begin
                step();
                n++;
            end
            chk("abort_three_ticks", ticks_seen, 3);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("abort_outputs", {corr_enable, corr_reset, snapshot, tx_valid, frame_ovf, busy}, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_quiet", {snapshot, tx_valid, busy}, 0);
        end
        chk("abort_count_kept", frame_count, 4);

        // zero length behaves as one tick; stop during WAIT_TX completes the frame
        integration_ticks = 32'd0;
        tx_ready          = 1'b0;
        exp_q.push_back('{1, 1'b0});
        start_frame();
        chk("start_clears_count", frame_count, 0);
        wait_for(0, "zero_len_snap");
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_pend_tx_held", tx_valid, 1);
        tx_ready = 1'b1;
        step();
        chk("stop_wait_idle", busy, 0);
        chk("stop_wait_count", frame_count, 1);
        step();
        chk("stop_wait_stays_idle", {busy, corr_reset}, 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", {busy, corr_reset}, 0);
        step();
        chk("start_stop_still_idle", busy, 0);

        // frame counter wrap
        integration_ticks = 32'd1;
        tick_period       = 1;
        for (int i = 0; i < 260; i++) exp_q.push_back('{1, 1'b0});
        start_frame();
        begin
            int n = 0;
            while (model_fc < 255 && n < 5000) begin
                step();
                n++;
            end
            chk("wrap_at_max", frame_count, 8'hFF);
            while (model_fc < 256 && n < 5000) begin
                step();
                n++;
            end
            chk("wrap_to_zero", frame_count, 8'h00);
        end

        // asynchronous reset during INTEGRATE
        wait_for(1, "pre_reset_integrate");
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {corr_enable, corr_reset, snapshot, tx_valid, frame_ovf, busy}, 0);
        chk("async_reset_count", frame_count, 0);
        exp_q.delete();
        exp_txv     = 1'b0;
        ticks_seen  = 0;
        model_fc    = 0;
        tick_period = 0;
        tick        = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_idle", {busy, corr_reset, corr_enable}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
